// File: rtl/stall_control_if.sv
// Purpose : bundles hazard_detect's stall request with the per-stage pipeline controls it produces.
// Latency : n/a (signal bundle only).
// Backpress: n/a; MemBusy is carried here as the pipeline-wide freeze request.
// Ports   : NoOp/BranchTaken/MemBusy/CntClear driven by the master (hazard/memory side);
//           PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, PipeFreeze, Stalling, StallCount,
//           StallCycles, FlushCount driven by the slave (stall_control).
interface stall_control_if #(
  parameter int CNT_W = 16
);
  logic [1:0]       NoOp;
  logic             BranchTaken;
  logic             MemBusy;
  logic             CntClear;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IFIDFlush;
  logic             IDEXBubble;
  logic             PipeFreeze;
  logic             Stalling;
  logic [1:0]       StallCount;
  logic [CNT_W-1:0] StallCycles;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output NoOp, BranchTaken, MemBusy, CntClear,
    input  PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, PipeFreeze,
           Stalling, StallCount, StallCycles, FlushCount
  );

  modport slave (
    input  NoOp, BranchTaken, MemBusy, CntClear,
    output PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, PipeFreeze,
           Stalling, StallCount, StallCycles, FlushCount
  );
endinterface

// File: rtl/stall_control.sv
// Purpose : turns hazard_detect's NoOp bubble count into PC/IF-ID hold, ID/EX bubble and IF/ID flush.
// Latency : combinational; a NoOp request stalls in the same cycle, STALL state covers the rest.
// Backpress: MemBusy freezes everything (state, owed bubbles, statistics) until it drops.
// Ports   : clk, reset (sync, active-high); ctl (stall_control_if.slave) carries the
//           request inputs, the per-stage enables, stall status and the saturating
//           StallCycles/FlushCount statistics.
module stall_control #(
  parameter int CNT_W       = 16,
  parameter int MAX_BUBBLES = 3
) (
  input  logic            clk,
  input  logic            reset,
  stall_control_if.slave  ctl
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01
  } state_t;

  localparam logic [1:0] MAX_N = 2'(MAX_BUBBLES);

  state_t           state;
  state_t           nextState;
  logic [1:0]       remaining;
  logic [1:0]       remainingNext;
  logic [CNT_W-1:0] stallCycles;
  logic [CNT_W-1:0] flushCount;

  logic [1:0]       nReq;
  logic             isStall;
  logic             pcWrite;
  logic             ifidWrite;
  logic             ifidFlush;
  logic             idexBubble;
  logic             pipeFreeze;
  logic             stallInc;
  logic             flushInc;

  assign nReq    = (ctl.NoOp > MAX_N) ? MAX_N : ctl.NoOp;
  assign isStall = (state == STALL);

  always_comb begin
    nextState     = RUN;
    remainingNext = remaining;
    pcWrite       = 1'b1;
    ifidWrite     = 1'b1;
    ifidFlush     = 1'b0;
    idexBubble    = 1'b0;
    pipeFreeze    = 1'b0;
    stallInc      = 1'b0;
    flushInc      = 1'b0;

    if (ctl.MemBusy) begin
      // Full freeze: nothing advances, owed bubbles are kept for later.
      // An illegal state encoding still falls back to RUN here.
      pcWrite   = 1'b0;
      ifidWrite = 1'b0;
      pipeFreeze = 1'b1;
      nextState = isStall ? STALL : RUN;
    end else if (isStall) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      idexBubble = 1'b1;
      stallInc   = 1'b1;
      if (remaining <= 2'd1) begin
        nextState     = RUN;
        remainingNext = 2'd0;
      end else begin
        nextState     = STALL;
        remainingNext = remaining - 2'd1;
      end
    end else if (nReq != 2'd0) begin
      // First bubble is issued this cycle; a taken branch is ignored because
      // its operands are the thing being waited for.
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      idexBubble = 1'b1;
      stallInc   = 1'b1;
      if (nReq == 2'd1) begin
        nextState     = RUN;
        remainingNext = 2'd0;
      end else begin
        nextState     = STALL;
        remainingNext = nReq - 2'd1;
      end
    end else begin
      ifidFlush     = ctl.BranchTaken;
      flushInc      = ctl.BranchTaken;
      nextState     = RUN;
      remainingNext = 2'd0;
    end

    // Reset drives the pipeline into a safe "hold and bubble" pattern.
    if (reset) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      ifidFlush  = 1'b1;
      idexBubble = 1'b1;
      pipeFreeze = 1'b0;
      stallInc   = 1'b0;
      flushInc   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      remaining   <= 2'd0;
      stallCycles <= '0;
      flushCount  <= '0;
    end else begin
      state     <= nextState;
      remaining <= remainingNext;

      // Clear wins over the same cycle's increment; counters stick at all-ones.
      if (ctl.CntClear) begin
        stallCycles <= '0;
        flushCount  <= '0;
      end else begin
        if (stallInc && (stallCycles != '1)) begin
          stallCycles <= stallCycles + CNT_W'(1);
        end
        if (flushInc && (flushCount != '1)) begin
          flushCount <= flushCount + CNT_W'(1);
        end
      end
    end
  end

  assign ctl.PCWrite     = pcWrite;
  assign ctl.IFIDWrite   = ifidWrite;
  assign ctl.IFIDFlush   = ifidFlush;
  assign ctl.IDEXBubble  = idexBubble;
  assign ctl.PipeFreeze  = pipeFreeze;
  assign ctl.Stalling    = reset ? 1'b0 : isStall;
  assign ctl.StallCount  = reset ? 2'd0 : remainingNext;
  assign ctl.StallCycles = stallCycles;
  assign ctl.FlushCount  = flushCount;

endmodule

// File: tb/tb_stall_control.sv
// Purpose : directed check of stall_control: reset forcing, NoOp stalls, MemBusy freeze, flushes, saturation.
// Latency : expectations are per cycle; each driven cycle queues one expected output word.
// Backpress: MemBusy sequences exercise the freeze path.
module tb_stall_control;

  logic clk;
  logic reset;

  stall_control_if #(.CNT_W(4)) ctl ();

  stall_control #(
    .CNT_W       (4),
    .MAX_BUBBLES (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (ctl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;

  // Packed layout: {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, PipeFreeze, Stalling,
  //                 StallCount[1:0], StallCycles[3:0], FlushCount[3:0]}
  function automatic logic [15:0] ex(input bit pcw, input bit ifw, input bit fl, input bit bub,
                                     input bit frz, input bit stl, input logic [1:0] cnt,
                                     input logic [3:0] sc, input logic [3:0] fc);
    return {pcw, ifw, fl, bub, frz, stl, cnt, sc, fc};
  endfunction

  function automatic logic [15:0] runE(input logic [3:0] sc, input logic [3:0] fc);
    return ex(1, 1, 0, 0, 0, 0, 2'd0, sc, fc);
  endfunction

  function automatic logic [15:0] bubE(input bit stl, input logic [1:0] cnt,
                                       input logic [3:0] sc, input logic [3:0] fc);
    return ex(0, 0, 0, 1, 0, stl, cnt, sc, fc);
  endfunction

  function automatic logic [15:0] frzE(input bit stl, input logic [1:0] cnt,
                                       input logic [3:0] sc, input logic [3:0] fc);
    return ex(0, 0, 0, 0, 1, stl, cnt, sc, fc);
  endfunction

  function automatic logic [15:0] rstE(input logic [3:0] sc, input logic [3:0] fc);
    return ex(0, 0, 1, 1, 0, 0, 2'd0, sc, fc);
  endfunction

  // Drive one cycle's inputs, queue its expectation, advance to just after the next edge.
  task automatic step(input string nm, input bit r, input logic [1:0] n, input bit b,
                      input bit m, input bit c, input logic [15:0] e);
    exp_t item;
    reset           = r;
    ctl.NoOp        = n;
    ctl.BranchTaken = b;
    ctl.MemBusy     = m;
    ctl.CntClear    = c;
    item.name = nm;
    item.exp  = e;
    expQ.push_back(item);
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle against the queue head.
  initial begin
    exp_t        e;
    logic [15:0] act;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e   = expQ.pop_front();
        act = {ctl.PCWrite, ctl.IFIDWrite, ctl.IFIDFlush, ctl.IDEXBubble, ctl.PipeFreeze,
               ctl.Stalling, ctl.StallCount, ctl.StallCycles, ctl.FlushCount};
        total++;
        if (act !== e.exp) begin
          bad++;
          $display("FAIL %s: got=%b want=%b (pcw ifw fl bub frz stl cnt2 sc4 fc4)",
                   e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset           = 1'b1;
    ctl.NoOp        = 2'd0;
    ctl.BranchTaken = 1'b0;
    ctl.MemBusy     = 1'b0;
    ctl.CntClear    = 1'b0;
    @(posedge clk);
    #1;

    // Reset for two cycles, then normal run.
    step("rst0",      1, 2'd0, 0, 0, 0, rstE(4'd0, 4'd0));
    step("rst1",      1, 2'd0, 0, 0, 0, rstE(4'd0, 4'd0));
    step("run0",      0, 2'd0, 0, 0, 0, runE(4'd0, 4'd0));

    // Single bubble.
    step("noop1",     0, 2'd1, 0, 0, 0, bubE(0, 2'd0, 4'd0, 4'd0));
    step("noop1_end", 0, 2'd0, 0, 0, 0, runE(4'd1, 4'd0));

    // Two bubbles.
    step("clr3",      0, 2'd0, 0, 0, 1, runE(4'd1, 4'd0));
    step("noop2_a",   0, 2'd2, 0, 0, 0, bubE(0, 2'd1, 4'd0, 4'd0));
    step("noop2_b",   0, 2'd0, 0, 0, 0, bubE(1, 2'd0, 4'd1, 4'd0));
    step("noop2_end", 0, 2'd0, 0, 0, 0, runE(4'd2, 4'd0));

    // MemBusy during STALL: frozen, owed bubble survives, inputs ignored.
    step("clr4",      0, 2'd0, 0, 0, 1, runE(4'd2, 4'd0));
    step("mb_noop2",  0, 2'd2, 0, 0, 0, bubE(0, 2'd1, 4'd0, 4'd0));
    step("mb_frz0",   0, 2'd3, 1, 1, 0, frzE(1, 2'd1, 4'd1, 4'd0));
    step("mb_frz1",   0, 2'd0, 0, 1, 0, frzE(1, 2'd1, 4'd1, 4'd0));
    step("mb_frz2",   0, 2'd1, 1, 1, 0, frzE(1, 2'd1, 4'd1, 4'd0));
    step("mb_resume", 0, 2'd0, 0, 0, 0, bubE(1, 2'd0, 4'd1, 4'd0));
    step("mb_end",    0, 2'd0, 0, 0, 0, runE(4'd2, 4'd0));

    // Branch flush, and branch suppressed by a concurrent stall.
    step("br_flush",  0, 2'd0, 1, 0, 0, ex(1, 1, 1, 0, 0, 0, 2'd0, 4'd2, 4'd0));
    step("br_stall",  0, 2'd1, 1, 0, 0, bubE(0, 2'd0, 4'd2, 4'd1));
    step("br_end",    0, 2'd0, 0, 0, 0, runE(4'd3, 4'd1));

    // Three bubbles; branch during STALL is ignored.
    step("noop3_a",   0, 2'd3, 0, 0, 0, bubE(0, 2'd2, 4'd3, 4'd1));
    step("noop3_b",   0, 2'd0, 1, 0, 0, bubE(1, 2'd1, 4'd4, 4'd1));
    step("noop3_c",   0, 2'd0, 0, 0, 0, bubE(1, 2'd0, 4'd5, 4'd1));
    step("noop3_end", 0, 2'd0, 0, 0, 0, runE(4'd6, 4'd1));

    // MemBusy in RUN beats NoOp and BranchTaken.
    step("mb_run",    0, 2'd2, 1, 1, 0, frzE(0, 2'd0, 4'd6, 4'd1));
    step("mb_run_end",0, 2'd0, 0, 0, 0, runE(4'd6, 4'd1));

    // Reset mid-stall (with MemBusy high) abandons owed bubbles and clears counters.
    step("rs_noop2",  0, 2'd2, 0, 0, 0, bubE(0, 2'd1, 4'd6, 4'd1));
    step("rs_reset",  1, 2'd0, 0, 1, 0, rstE(4'd7, 4'd1));
    step("rs_after",  0, 2'd0, 0, 0, 0, runE(4'd0, 4'd0));

    // Saturation of StallCycles at 15, then clear overriding the increment.
    for (int i = 0; i < 20; i++) begin
      step($sformatf("sat%0d", i), 0, 2'd1, 0, 0, 0,
           bubE(0, 2'd0, (i > 15) ? 4'd15 : 4'(i), 4'd0));
    end
    step("sat_clr",   0, 2'd1, 0, 0, 1, bubE(0, 2'd0, 4'd15, 4'd0));
    step("sat_after", 0, 2'd0, 0, 0, 0, runE(4'd0, 4'd0));

    // Every queued expectation must have been consumed by the monitor.
    for (int k = 0; k < 4; k++) begin
      if (expQ.size() == 0) break;
      @(negedge clk);
    end
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("FAIL drain: got=%0d pending want=0", expQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
